// File: rtl/lz4_hash_lookup.sv
// LZ4 hash-table candidate finder: hashes a 4-byte window, returns the most recent
// address with the same hash, records the current address, and reports match offset.
module lz4_hash_lookup #(
  parameter int HASH_BITS = 12,
  parameter int MAX_DIST  = 65535
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        blk_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic [31:0] cand_addr,
  output logic        cand_hit,
  output logic [15:0] cand_offset,
  output logic        busy
);

  localparam int          ENTRIES    = 1 << HASH_BITS;
  localparam logic [31:0] GOLDEN     = 32'h9E3779B1;
  localparam logic [31:0] MAX_DIST_W = 32'(MAX_DIST);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t               state_q, state_d;
  logic [HASH_BITS-1:0] clr_idx_q, clr_idx_d;

  logic                 tbl_vld  [ENTRIES];
  logic [31:0]          tbl_addr [ENTRIES];

  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_data_q, out_data_d;
  logic [31:0]          out_addr_q, out_addr_d;
  logic [31:0]          cand_addr_q, cand_addr_d;
  logic                 cand_hit_q, cand_hit_d;
  logic [15:0]          cand_offset_q, cand_offset_d;

  logic                 accept;
  logic [HASH_BITS-1:0] h;
  logic                 ent_vld;
  logic [31:0]          ent_addr;
  logic [31:0]          diff;
  logic                 hit_c;

  // Upper HASH_BITS of the 32-bit truncated multiplicative hash.
  function automatic logic [HASH_BITS-1:0] hash_fn(input logic [31:0] d);
    logic [31:0] p;
    p = d * GOLDEN;
    return p[31 -: HASH_BITS];
  endfunction

  assign in_ready = (state_q == RUN) && !blk_start && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == CLEAR);

  // Asynchronous read gives the pre-write entry in the accept cycle.
  assign h        = hash_fn(in_data);
  assign ent_vld  = tbl_vld[h];
  assign ent_addr = tbl_addr[h];
  assign diff     = in_addr - ent_addr;
  assign hit_c    = ent_vld && (diff != 32'd0) && (diff <= MAX_DIST_W);

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      CLEAR: begin
        if (blk_start) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == '1) begin
          state_d   = RUN;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + HASH_BITS'(1);
        end
      end
      RUN: begin
        if (blk_start) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  always_comb begin
    out_valid_d   = accept || (out_valid_q && !out_ready);
    out_data_d    = out_data_q;
    out_addr_d    = out_addr_q;
    cand_addr_d   = cand_addr_q;
    cand_hit_d    = cand_hit_q;
    cand_offset_d = cand_offset_q;
    if (accept) begin
      out_data_d    = in_data;
      out_addr_d    = in_addr;
      cand_addr_d   = ent_vld ? ent_addr : 32'd0;
      cand_hit_d    = hit_c;
      cand_offset_d = hit_c ? diff[15:0] : 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= CLEAR;
      clr_idx_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_addr_q    <= '0;
      cand_addr_q   <= '0;
      cand_hit_q    <= 1'b0;
      cand_offset_q <= '0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_addr_q    <= out_addr_d;
      cand_addr_q   <= cand_addr_d;
      cand_hit_q    <= cand_hit_d;
      cand_offset_q <= cand_offset_d;
    end
  end

  // Table storage is not reset; the CLEAR sweep invalidates it.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      tbl_vld[clr_idx_q] <= 1'b0;
    end else if (accept) begin
      tbl_vld[h]  <= 1'b1;
      tbl_addr[h] <= in_addr;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_addr    = out_addr_q;
  assign cand_addr   = cand_addr_q;
  assign cand_hit    = cand_hit_q;
  assign cand_offset = cand_offset_q;

endmodule

// File: tb/tb_lz4_hash_lookup.sv
// Scoreboard bench for lz4_hash_lookup: directed windows with hand-computed candidates.
`timescale 1ns/1ps
module tb_lz4_hash_lookup;

  logic        clk = 1'b0;
  logic        rstN;
  logic        blk_start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic [31:0] cand_addr;
  logic        cand_hit;
  logic [15:0] cand_offset;
  logic        busy;

  lz4_hash_lookup dut (
    .clk(clk), .rstN(rstN), .blk_start(blk_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .cand_addr(cand_addr), .cand_hit(cand_hit), .cand_offset(cand_offset), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] caddr;
    logic        hit;
    logic [15:0] off;
    bit          b2b;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   last_xfer = -10;

  localparam logic [31:0] W = 32'h64636261;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstN && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_addr", out_addr, e.addr);
          chk("cand_addr", cand_addr, e.caddr);
          chk("cand_hit", 32'(cand_hit), 32'(e.hit));
          chk("cand_offset", 32'(cand_offset), 32'(e.off));
          if (e.b2b) chk("no_bubble", 32'(cyc - last_xfer), 32'd1);
        end
        last_xfer = cyc;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [31:0] a, input logic [31:0] ca,
                      input logic h, input logic [15:0] o, input bit b2b, input bit push);
    int t;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_addr  = a;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 10000) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("in_ready_wait", 32'(in_ready), 32'd1);
    end else if (push) begin
      e.data = d; e.addr = a; e.caddr = ca; e.hit = h; e.off = o; e.b2b = b2b;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_not_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 10000) begin
      if (in_ready) chk("in_ready_while_busy", 32'(in_ready), 32'd0);
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int bc;
    rstN = 1'b0; blk_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cand_hit", 32'(cand_hit), 32'd0);
    chk("rst_cand_offset", 32'(cand_offset), 32'd0);
    chk("rst_cand_addr", cand_addr, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    @(negedge clk);
    rstN = 1'b1;
    wait_not_busy(bc);
    chk("busy_cycles", 32'(bc), 32'd4096);
    chk("in_ready_after_clear", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // First sighting misses, repeat at addr 8 hits.
    send(W, 32'd0, 32'd0, 1'b0, 16'd0, 1'b0, 1'b1);
    send(W, 32'd8, 32'd0, 1'b1, 16'd8, 1'b0, 1'b1);
    // Back-to-back same hash.
    send(W, 32'd100, 32'd8, 1'b1, 16'd92, 1'b0, 1'b1);
    send(W, 32'd101, 32'd100, 1'b1, 16'd1, 1'b1, 1'b1);
    // Backward address is a wrapped huge diff -> miss; distance limit.
    send(W, 32'd0, 32'd101, 1'b0, 16'd0, 1'b0, 1'b1);
    send(W, 32'd65536, 32'd0, 1'b0, 16'd0, 1'b0, 1'b1);
    send(W, 32'd65537, 32'd65536, 1'b1, 16'd1, 1'b0, 1'b1);
    // Address wrap past 2^32, then zero distance.
    send(W, 32'hFFFF_FFF0, 32'd65537, 1'b0, 16'd0, 1'b0, 1'b1);
    send(W, 32'd5, 32'hFFFF_FFF0, 1'b1, 16'd21, 1'b0, 1'b1);
    send(W, 32'd5, 32'd5, 1'b0, 16'd0, 1'b0, 1'b1);

    // Stall: hold one result, offer another window for 5 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(W, 32'd200, 32'd5, 1'b1, 16'd195, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = W; in_addr = 32'd300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_addr", out_addr, 32'd200);
      chk("stall_cand_offset", 32'(cand_offset), 32'd195);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(W, 32'd300, 32'd200, 1'b1, 16'd100, 1'b1, 1'b1);

    // Block restart with a simultaneous window that must be refused.
    send(W, 32'd0, 32'd300, 1'b0, 16'd0, 1'b0, 1'b1);
    blk_start = 1'b1; in_valid = 1'b1; in_data = W; in_addr = 32'd7;
    @(negedge clk);
    chk("blk_start_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    blk_start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("blk_start_busy", 32'(busy), 32'd1);
    wait_not_busy(bc);
    chk("reclear_cycles", 32'(bc), 32'd4096);
    @(posedge clk); #1;
    send(W, 32'd20, 32'd0, 1'b0, 16'd0, 1'b0, 1'b1);
    send(W, 32'd40, 32'd20, 1'b1, 16'd20, 1'b0, 1'b1);

    // Reset mid-operation with a held result.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(W, 32'd50, 32'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_cand_addr", cand_addr, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lz4_hash_lookup.md
# lz4_hash_lookup

Hash-table candidate finder for the LZ4 compressor, directly downstream of the absolute input-address counter. Each cycle it takes a 4-byte input window plus that window's absolute address, hashes the window, and returns the most recent address that produced the same hash. It records the current address in the table and reports the backward offset when the candidate lies within LZ4 match distance. Its output feeds the match-verify/extend stage, which does the byte compare.

## Interface
- HASH_BITS, 12, log2 of table entries (2^HASH_BITS entries, each 1 valid bit + 32-bit address)
- MAX_DIST, 65535, largest legal match offset
- clk  in  1  system clock, rising edge
- rstN  in  1  asynchronous, active-low reset
- blk_start  in  1  single-cycle pulse; invalidate whole table (new independent block)
- in_valid  in  1  window/address valid
- in_ready  out  1  block can accept this cycle
- in_data  in  32  4-byte window, byte 0 in [7:0]
- in_addr  in  32  absolute address of byte 0 (from the address counter)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  32  echoed in_data
- out_addr  out  32  echoed in_addr
- cand_addr  out  32  stored address for this hash (0 when entry invalid)
- cand_hit  out  1  candidate usable
- cand_offset  out  16  out_addr − cand_addr when cand_hit, else 0
- busy  out  1  table clear in progress

## Operation
- Hash: h = (in_data × 32'h9E3779B1)[31:32−HASH_BITS], i.e. the upper HASH_BITS bits of the 32-bit product, with the product truncated to 32 bits.
- Control FSM has two states: CLEAR and RUN.
  - Reset enters CLEAR with clr_idx = 0.
  - CLEAR: each cycle write entry[clr_idx].valid = 0 and increment clr_idx. After entry 2^HASH_BITS−1 is written, go to RUN.
  - RUN: on blk_start, go to CLEAR with clr_idx = 0.
  - blk_start during CLEAR restarts clr_idx at 0.
- busy = (state == CLEAR).
- in_ready = (state == RUN) && !blk_start && (!out_valid || out_ready). This path is combinational from blk_start and out_ready.
- Accept (in_valid && in_ready):
  - Read entry[h].
  - In the same cycle write entry[h] = {1, in_addr}. The read uses read-before-write semantics and returns the old value.
- Result for each accepted window:
  - diff = in_addr − entry.addr, computed modulo 2^32.
  - cand_hit = entry.valid && diff != 0 && diff <= MAX_DIST.
  - cand_offset = cand_hit ? diff[15:0] : 0.
  - cand_addr = entry.valid ? entry.addr : 0.
- Back-to-back windows with the same hash: the second lookup sees the first window's address, because the write lands before the next cycle's read.
- A pending output when blk_start arrives still drains normally. Only the table is cleared.
- Address wrap past 2^32: handled by the modulo subtraction. An entry whose diff exceeds MAX_DIST is a miss but is still overwritten.
- The block never compares data bytes; false hash collisions are rejected downstream.

## Timing
- Reset values:
  - out_valid = 0, cand_hit = 0, cand_offset = 0, cand_addr = 0, out_data = 0, out_addr = 0.
  - busy = 1, in_ready = 0.
  - Table contents are not reset; they are invalidated by the CLEAR sweep.
- After rstN deasserts, busy stays 1 for exactly 2^HASH_BITS cycles (4096 by default). in_ready may rise on the next cycle.
- Latency: a window accepted on cycle T appears with out_valid = 1 on cycle T+1.
- Throughput: 1 window per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, all out_* and cand_* hold stable. No table read or write occurs.
- out_valid clears on the cycle after acceptance (out_valid && out_ready) unless a new window was accepted in the same cycle.
- blk_start and in_valid in the same cycle: the window is not accepted; CLEAR begins next cycle.
- blk_start during a stall: clearing proceeds, and the held output is unaffected.
- Reset asserted mid-operation: all outputs return to their reset values immediately, and a full CLEAR sweep follows.

## Test plan
- Reset, out_ready=1: busy high for 4096 cycles, in_ready=0 throughout; then in_ready=1.
- Window 32'h64636261 at addr 0 → cand_hit=0, cand_addr=0. Same data at addr 8 → cand_hit=1, cand_addr=0, cand_offset=8.
- Same data at addrs 100, 101 back-to-back → second result: cand_hit=1, cand_offset=1, arriving with no bubble.
- Same data at addr 0, then at addr 65536 → cand_hit=0, cand_addr=0 (diff > 65535); then at addr 65537 → cand_hit=1, offset=1.
- out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, outputs frozen, no table update; release → exactly one result per accepted window, in order.
- Populate addr 0, pulse blk_start, wait for busy to fall, repeat the data at addr 20 → cand_hit=0. Also drive blk_start and in_valid together → window not accepted.
